// File: rtl/easyaxi_rd_slice.sv
// AXI read-path register slice: AR and R channels each pass through a 2-entry skid buffer,
// and an outstanding-burst counter throttles AR acceptance at MAX_OUTS.

module easyaxi_rd_slice_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_allow,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_pld,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_pld
);

  logic         main_vld_reg;
  logic         skid_vld_reg;
  logic [W-1:0] main_pld_reg;
  logic [W-1:0] skid_pld_reg;
  logic         in_hs;
  logic         main_free;

  // Ready comes from registers only, so nothing combinational crosses the slice.
  assign in_ready  = !skid_vld_reg && in_allow;
  assign in_hs     = in_valid && in_ready;
  assign main_free = !main_vld_reg || out_ready;
  assign out_valid = main_vld_reg;
  assign out_pld   = main_pld_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_reg <= 1'b0;
      skid_vld_reg <= 1'b0;
      main_pld_reg <= '0;
      skid_pld_reg <= '0;
    end else if (main_free) begin
      if (skid_vld_reg) begin
        // Skid full implies in_ready was 0, so no new beat competes this cycle.
        main_vld_reg <= 1'b1;
        main_pld_reg <= skid_pld_reg;
        skid_vld_reg <= 1'b0;
      end else begin
        main_vld_reg <= in_hs;
        if (in_hs) main_pld_reg <= in_pld;
      end
    end else if (in_hs) begin
      skid_vld_reg <= 1'b1;
      skid_pld_reg <= in_pld;
    end
  end

endmodule

module easyaxi_rd_slice #(
  parameter int ID_W     = 4,
  parameter int ADDR_W   = 32,
  parameter int LEN_W    = 8,
  parameter int SIZE_W   = 3,
  parameter int BURST_W  = 2,
  parameter int DATA_W   = 64,
  parameter int RESP_W   = 2,
  parameter int MAX_OUTS = 4,
  localparam int AR_W    = ID_W + ADDR_W + LEN_W + SIZE_W + BURST_W,
  localparam int R_W     = DATA_W + RESP_W + 1,
  localparam int OUTS_W  = $clog2(MAX_OUTS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_arvalid,
  output logic              up_arready,
  input  logic [AR_W-1:0]   up_arpld,
  output logic              dn_arvalid,
  input  logic              dn_arready,
  output logic [AR_W-1:0]   dn_arpld,
  input  logic              dn_rvalid,
  output logic              dn_rready,
  input  logic [R_W-1:0]    dn_rpld,
  output logic              up_rvalid,
  input  logic              up_rready,
  output logic [R_W-1:0]    up_rpld,
  output logic [OUTS_W-1:0] outs_cnt
);

  logic [OUTS_W-1:0] outs_cnt_reg;
  logic              ar_room;
  logic              ar_acc;
  logic              r_done;

  assign ar_room  = outs_cnt_reg < OUTS_W'(MAX_OUTS);
  assign ar_acc   = up_arvalid && up_arready;
  assign r_done   = up_rvalid && up_rready && up_rpld[0];
  assign outs_cnt = outs_cnt_reg;

  easyaxi_rd_slice_skid #(.W(AR_W)) u_ar_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_allow  (ar_room),
    .in_valid  (up_arvalid),
    .in_ready  (up_arready),
    .in_pld    (up_arpld),
    .out_valid (dn_arvalid),
    .out_ready (dn_arready),
    .out_pld   (dn_arpld)
  );

  easyaxi_rd_slice_skid #(.W(R_W)) u_r_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_allow  (1'b1),
    .in_valid  (dn_rvalid),
    .in_ready  (dn_rready),
    .in_pld    (dn_rpld),
    .out_valid (up_rvalid),
    .out_ready (up_rready),
    .out_pld   (up_rpld)
  );

  // A last beat with nothing outstanding is illegal upstream; the counter saturates at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outs_cnt_reg <= '0;
    end else if (ar_acc && !r_done) begin
      outs_cnt_reg <= outs_cnt_reg + OUTS_W'(1);
    end else if (!ar_acc && r_done && outs_cnt_reg != '0) begin
      outs_cnt_reg <= outs_cnt_reg - OUTS_W'(1);
    end
  end

endmodule
